// File: rtl/hex_entry_pkg.sv
// rtl/hex_entry_pkg.sv - shared constants and types for the hex entry encoder
package hex_entry_pkg;

    localparam int DIGIT_W  = 4;
    localparam int NUM_BTNS = 5;

    localparam int BTN_CENTER = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_RIGHT  = 4;

    typedef enum logic {
        ST_EDIT        = 1'b0,
        ST_COMMIT_WAIT = 1'b1
    } state_e;

    // One hex digit step; wraps naturally in 4 bits, so there is never a carry out
    function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] d,
                                                      input logic              up);
        return up ? (d + 4'd1) : (d - 4'd1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchroniser, level debouncer and press-event generator
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the raw button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // Count consecutive cycles the synchronised level disagrees with the accepted level
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Accepted level, stability counter and one-cycle press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/hex_entry_encoder.sv
// rtl/hex_entry_encoder.sv - five-button hex digit editor with valid/ready commit; optional HEX_ENTRY_AUTOREPEAT_EN
module hex_entry_encoder
    import hex_entry_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             btn_up,
    input  logic                                             btn_down,
    input  logic                                             btn_left,
    input  logic                                             btn_right,
    input  logic                                             btn_center,
    output logic [4*NUM_DIGITS-1:0]                          value_out,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] cursor,
    output logic [4*NUM_DIGITS-1:0]                          commit_data,
    output logic                                             commit_valid,
    input  logic                                             commit_ready
);

    localparam int W  = DIGIT_W * NUM_DIGITS;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CUR_LAST = CW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CUR_ONE  = CW'(1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;

    assign btn_raw[BTN_CENTER] = btn_center;
    assign btn_raw[BTN_UP]     = btn_up;
    assign btn_raw[BTN_DOWN]   = btn_down;
    assign btn_raw[BTN_LEFT]   = btn_left;
    assign btn_raw[BTN_RIGHT]  = btn_right;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (btn_raw[i]),
            .level_o(btn_level[i]),
            .press_o(btn_press[i])
        );
    end

    state_e         state_q;
    logic [W-1:0]   value_q;
    logic [CW-1:0]  cursor_q;
    logic [W-1:0]   commit_data_q;
    logic           commit_valid_q;

    logic           up_evt;
    logic           down_evt;
    logic [DIGIT_W-1:0] cur_digit;

    assign cur_digit = value_q[int'(cursor_q)*DIGIT_W +: DIGIT_W];

`ifdef HEX_ENTRY_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_phase_q, rep_phase_d;
    logic          rep_fire;
    logic          rep_hold;
    logic          unused_level_bits;

    assign rep_hold          = btn_level[BTN_UP] | btn_level[BTN_DOWN];
    assign unused_level_bits = ^{btn_level[BTN_CENTER], btn_level[BTN_LEFT], btn_level[BTN_RIGHT]};

    // Time the first repeat from the press event, then the steady repeat period
    always_comb begin
        rep_fire    = 1'b0;
        rep_cnt_d   = rep_cnt_q + RW'(1);
        rep_phase_d = rep_phase_q;
        if (state_q != ST_EDIT || !rep_hold || (|btn_press)) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (rep_cnt_q == (rep_phase_q ? REP_NEXT : REP_FIRST)) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
        end
    end

    // Repeat counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    // Up wins a repeat when both are held, matching the press priority
    assign up_evt   = btn_press[BTN_UP]   | (rep_fire & btn_level[BTN_UP]);
    assign down_evt = btn_press[BTN_DOWN] | (rep_fire & ~btn_level[BTN_UP] & btn_level[BTN_DOWN]);
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    logic [NUM_BTNS-1:0] unused_level;

    assign unused_level = btn_level;
    assign up_evt       = btn_press[BTN_UP];
    assign down_evt     = btn_press[BTN_DOWN];
`endif

    // Edit/commit FSM: one action per cycle, center > up > down > left > right
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EDIT;
            value_q        <= '0;
            cursor_q       <= '0;
            commit_data_q  <= '0;
            commit_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EDIT: begin
                    if (btn_press[BTN_CENTER]) begin
                        commit_data_q  <= value_q;
                        commit_valid_q <= 1'b1;
                        state_q        <= ST_COMMIT_WAIT;
                    end else if (up_evt) begin
                        value_q[int'(cursor_q)*DIGIT_W +: DIGIT_W] <= digit_step(cur_digit, 1'b1);
                    end else if (down_evt) begin
                        value_q[int'(cursor_q)*DIGIT_W +: DIGIT_W] <= digit_step(cur_digit, 1'b0);
                    end else if (btn_press[BTN_LEFT]) begin
                        cursor_q <= (cursor_q == CUR_LAST) ? '0 : cursor_q + CUR_ONE;
                    end else if (btn_press[BTN_RIGHT]) begin
                        cursor_q <= (cursor_q == '0) ? CUR_LAST : cursor_q - CUR_ONE;
                    end
                end
                ST_COMMIT_WAIT: begin
                    if (commit_ready) begin
                        commit_valid_q <= 1'b0;
                        state_q        <= ST_EDIT;
                    end
                end
                default: begin
                    state_q        <= ST_EDIT;
                    commit_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign value_out    = value_q;
    assign cursor       = cursor_q;
    assign commit_data  = commit_data_q;
    assign commit_valid = commit_valid_q;

endmodule

// File: tb/tb_hex_entry_encoder.sv
// tb/tb_hex_entry_encoder.sv - scoreboard bench for hex_entry_encoder with directed button vectors
module tb_hex_entry_encoder;

    localparam logic [4:0] M_CENTER = 5'b00001;
    localparam logic [4:0] M_UP     = 5'b00010;
    localparam logic [4:0] M_DOWN   = 5'b00100;
    localparam logic [4:0] M_LEFT   = 5'b01000;
    localparam logic [4:0] M_RIGHT  = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  btn_vec = '0;
    logic        commit_ready = 1'b0;
    logic [15:0] value_out;
    logic [1:0]  cursor;
    logic [15:0] commit_data;
    logic        commit_valid;

    int errors = 0;
    int checks = 0;

    logic [17:0] exp_q[$];
    logic [15:0] commit_q[$];

    always #5 clk = ~clk;

    hex_entry_encoder #(
        .NUM_DIGITS     (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btn_vec[1]),
        .btn_down    (btn_vec[2]),
        .btn_left    (btn_vec[3]),
        .btn_right   (btn_vec[4]),
        .btn_center  (btn_vec[0]),
        .value_out   (value_out),
        .cursor      (cursor),
        .commit_data (commit_data),
        .commit_valid(commit_valid),
        .commit_ready(commit_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every visible edit and every commit transfer is matched against the scoreboard
    initial begin
        logic [15:0] prev_v;
        logic [1:0]  prev_c;
        logic [17:0] e;
        prev_v = '0;
        prev_c = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = value_out;
                prev_c = cursor;
            end else begin
                if (value_out !== prev_v || cursor !== prev_c) begin
                    if (exp_q.size() == 0) begin
                        chk("edit_unexpected", {14'd0, cursor, value_out}, {14'd0, prev_c, prev_v});
                    end else begin
                        e = exp_q.pop_front();
                        chk("edit_step", {14'd0, cursor, value_out}, {14'd0, e});
                    end
                end
                if (commit_valid && commit_ready) begin
                    if (commit_q.size() == 0) begin
                        chk("commit_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("commit_data", {16'd0, commit_data}, {16'd0, commit_q.pop_front()});
                    end
                end
                prev_v = value_out;
                prev_c = cursor;
            end
        end
    end

    task automatic hold_btn(input logic [4:0] mask, input int cycles);
        @(posedge clk); #1;
        btn_vec = mask;
        repeat (cycles) @(posedge clk);
        #1;
        btn_vec = '0;
    endtask

    task automatic press(input logic [4:0] mask);
        hold_btn(mask, 8);
        repeat (10) @(posedge clk);
    endtask

    task automatic step(input logic [4:0] mask, input logic [15:0] v, input logic [1:0] c);
        exp_q.push_back({c, v});
        press(mask);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_value", {16'd0, value_out}, 32'h0);
        chk("rst_cursor", {30'd0, cursor}, 32'h0);
        chk("rst_cdata", {16'd0, commit_data}, 32'h0);
        chk("rst_cvalid", {31'd0, commit_valid}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // First press latency: raw high after edge 0, step visible after edge 7
        exp_q.push_back({2'd0, 16'h0001});
        @(posedge clk); #1;
        btn_vec = M_UP;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("lat_edge6", {16'd0, value_out}, 32'h0000);
        @(posedge clk);
        @(negedge clk);
        chk("lat_edge7", {16'd0, value_out}, 32'h0001);
        repeat (3) @(posedge clk);
        #1;
        btn_vec = '0;
        repeat (12) @(posedge clk);
        chk("held_one_step", {16'd0, value_out}, 32'h0001);

        // Fifteen more presses wrap digit 0 back to 0 without carrying
        for (int i = 1; i < 16; i++) begin
            step(M_UP, 16'((i + 1) % 16), 2'd0);
        end
        chk("wrap_no_carry", {16'd0, value_out}, 32'h0000);

        // Bounces shorter than the debounce window are rejected
        @(posedge clk); #1;
        btn_vec = M_UP;
        repeat (3) @(posedge clk);
        #1;
        btn_vec = '0;
        @(posedge clk); #1;
        btn_vec = M_UP;
        repeat (3) @(posedge clk);
        #1;
        btn_vec = '0;
        repeat (12) @(posedge clk);
        chk("glitch_value", {16'd0, value_out}, 32'h0000);

        // Cursor movement with wrap
        step(M_LEFT, 16'h0000, 2'd1);
        step(M_UP,   16'h0010, 2'd1);
        step(M_UP,   16'h0020, 2'd1);
        step(M_LEFT, 16'h0020, 2'd2);
        step(M_LEFT, 16'h0020, 2'd3);
        step(M_LEFT, 16'h0020, 2'd0);
        step(M_DOWN, 16'h002F, 2'd0);
        step(M_RIGHT, 16'h002F, 2'd3);
        step(M_LEFT, 16'h002F, 2'd0);
        chk("cursor_seq", {30'd0, cursor}, 32'h0);
        chk("value_seq", {16'd0, value_out}, 32'h002F);

        // Build 0xBEEF from reset
        do_reset();
        chk("rst2_value", {16'd0, value_out}, 32'h0);
        step(M_DOWN, 16'h000F, 2'd0);
        step(M_LEFT, 16'h000F, 2'd1);
        step(M_DOWN, 16'h00FF, 2'd1);
        step(M_DOWN, 16'h00EF, 2'd1);
        step(M_LEFT, 16'h00EF, 2'd2);
        step(M_DOWN, 16'h0FEF, 2'd2);
        step(M_DOWN, 16'h0EEF, 2'd2);
        step(M_LEFT, 16'h0EEF, 2'd3);
        step(M_DOWN, 16'hFEEF, 2'd3);
        step(M_DOWN, 16'hEEEF, 2'd3);
        step(M_DOWN, 16'hDEEF, 2'd3);
        step(M_DOWN, 16'hCEEF, 2'd3);
        step(M_DOWN, 16'hBEEF, 2'd3);

        // Commit with downstream stalled; presses during the wait are dropped
        commit_q.push_back(16'hBEEF);
        @(posedge clk); #1;
        btn_vec = M_CENTER;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("cv_high", {31'd0, commit_valid}, 32'h1);
        chk("cdata_latched", {16'd0, commit_data}, 32'hBEEF);
        @(posedge clk); #1;
        btn_vec = '0;
        repeat (10) @(posedge clk);
        press(M_UP);
        press(M_LEFT);
        @(negedge clk);
        chk("cv_still_high", {31'd0, commit_valid}, 32'h1);
        chk("wait_value", {16'd0, value_out}, 32'hBEEF);
        chk("wait_cursor", {30'd0, cursor}, 32'h3);
        @(posedge clk); #1;
        commit_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("cv_drop", {31'd0, commit_valid}, 32'h0);
        #1;
        commit_ready = 1'b0;
        step(M_UP, 16'hCEEF, 2'd3);

        // Center and up together: only the commit happens
        commit_q.push_back(16'hCEEF);
        press(M_CENTER | M_UP);
        @(negedge clk);
        chk("simul_cv", {31'd0, commit_valid}, 32'h1);
        chk("simul_value", {16'd0, value_out}, 32'hCEEF);
        chk("simul_cdata", {16'd0, commit_data}, 32'hCEEF);

        // Asynchronous reset in COMMIT_WAIT drops the pending commit
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_value", {16'd0, value_out}, 32'h0);
        chk("arst_cursor", {30'd0, cursor}, 32'h0);
        chk("arst_cdata", {16'd0, commit_data}, 32'h0);
        chk("arst_cvalid", {31'd0, commit_valid}, 32'h0);
        commit_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        commit_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_rst_cvalid", {31'd0, commit_valid}, 32'h0);
        commit_ready = 1'b0;

        // Ready high at commit time: valid lasts exactly one cycle
        commit_q.push_back(16'h0000);
        commit_ready = 1'b1;
        @(posedge clk); #1;
        btn_vec = M_CENTER;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("fast_cv_high", {31'd0, commit_valid}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("fast_cv_low", {31'd0, commit_valid}, 32'h0);
        #1;
        btn_vec = '0;
        commit_ready = 1'b0;
        repeat (14) @(posedge clk);

`ifdef HEX_ENTRY_AUTOREPEAT_EN
        // Hold up for 40 cycles: press step at edge 7, repeats at edges 27, 32, 37, 42
        do_reset();
        for (int k = 1; k <= 5; k++) exp_q.push_back({2'd0, 16'(k)});
        @(posedge clk); #1;
        btn_vec = M_UP;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk);
            if (e == 40) begin
                #1;
                btn_vec = '0;
            end
            @(negedge clk);
            case (e)
                7:  chk("rep_e7",  {16'd0, value_out}, 32'h1);
                26: chk("rep_e26", {16'd0, value_out}, 32'h1);
                27: chk("rep_e27", {16'd0, value_out}, 32'h2);
                31: chk("rep_e31", {16'd0, value_out}, 32'h2);
                32: chk("rep_e32", {16'd0, value_out}, 32'h3);
                37: chk("rep_e37", {16'd0, value_out}, 32'h4);
                41: chk("rep_e41", {16'd0, value_out}, 32'h4);
                42: chk("rep_e42", {16'd0, value_out}, 32'h5);
                50: chk("rep_e50", {16'd0, value_out}, 32'h5);
                default: ;
            endcase
        end
        repeat (5) @(posedge clk);
`endif

        @(negedge clk);
        chk("edit_queue_empty", exp_q.size(), 32'd0);
        chk("commit_queue_empty", commit_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
